// File: rtl/pipe_pkg.sv
// Shared pipeline decode helpers: opcodes, NOP encoding and register-field extractors
// that return x0 for fields an instruction does not actually read or write.
package pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  function automatic logic is_load(input logic [31:0] inst);
    return inst[6:0] == OP_LOAD;
  endfunction

  // Stores and branches carry immediate bits in the rd slot.
  function automatic logic [4:0] get_rd(input logic [31:0] inst);
    if (inst[6:0] == OP_STORE || inst[6:0] == OP_BRANCH) return 5'd0;
    return inst[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] inst);
    if (inst[6:0] == OP_LUI || inst[6:0] == OP_AUIPC || inst[6:0] == OP_JAL) return 5'd0;
    return inst[19:15];
  endfunction

  // Store data rs2 is deliberately excluded: store forwarding covers it.
  function automatic logic [4:0] get_rs2(input logic [31:0] inst);
    if (inst[6:0] == OP_RTYPE || inst[6:0] == OP_BRANCH) return inst[24:20];
    return 5'd0;
  endfunction

endpackage

// File: rtl/pipe_inst_tracker_load_use_detect.sv
// Combinational load-use hazard detection: a load in X or M producing a register D reads.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [31:0] inst_d_i,
  input  logic [31:0] inst_x_i,
  input  logic [31:0] inst_m_i,
  output logic        load_use_o
);

  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_x;
  logic [4:0] rd_m;
  logic       hit_x;
  logic       hit_m;

  // rd != 0 guarantees an x0 source (masked or real) never matches.
  always_comb begin
    rs1_d = get_rs1(inst_d_i);
    rs2_d = get_rs2(inst_d_i);
    rd_x  = get_rd(inst_x_i);
    rd_m  = get_rd(inst_m_i);
    hit_x = is_load(inst_x_i) && (rd_x != 5'd0) && ((rd_x == rs1_d) || (rd_x == rs2_d));
    hit_m = is_load(inst_m_i) && (rd_m != 5'd0) && ((rd_m == rs1_d) || (rd_m == rs2_d));
    load_use_o = hit_x || hit_m;
  end

endmodule

// File: rtl/pipe_inst_tracker.sv
// D/X/M/W instruction tracker with load-use bubbles, branch squash, memory freeze
// and saturating stall/flush event counters.
module pipe_inst_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_f_i,
  input  logic             fetch_valid_i,
  input  logic             br_taken_i,
  input  logic             dmem_wait_i,
  output logic [31:0]      instD_com_o,
  output logic [31:0]      instX_com_o,
  output logic [31:0]      instM_com_o,
  output logic [31:0]      instW_com_o,
  output logic             stall_f_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      inst_d_q, inst_d_d;
  logic [31:0]      inst_x_q, inst_x_d;
  logic [31:0]      inst_m_q, inst_m_d;
  logic [31:0]      inst_w_q, inst_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             inc_stall;
  logic             inc_flush;

  load_use_detect u_lud (
    .inst_d_i   (inst_d_q),
    .inst_x_i   (inst_x_q),
    .inst_m_i   (inst_m_q),
    .load_use_o (load_use)
  );

  always_comb begin
    inst_d_d  = inst_d_q;
    inst_x_d  = inst_x_q;
    inst_m_d  = inst_m_q;
    inst_w_d  = inst_w_q;
    stall_f_o = 1'b0;
    flush_o   = 1'b0;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    if (dmem_wait_i) begin
      stall_f_o = 1'b1;
    end else if (br_taken_i) begin
      // Wrong-path D and the in-flight fetch are both dropped.
      inst_d_d  = NOP_INST;
      inst_x_d  = NOP_INST;
      inst_m_d  = inst_x_q;
      inst_w_d  = inst_m_q;
      flush_o   = 1'b1;
      inc_flush = 1'b1;
    end else if (load_use) begin
      inst_x_d  = NOP_INST;
      inst_m_d  = inst_x_q;
      inst_w_d  = inst_m_q;
      stall_f_o = 1'b1;
      inc_stall = 1'b1;
    end else begin
      inst_d_d  = fetch_valid_i ? inst_f_i : NOP_INST;
      inst_x_d  = inst_d_q;
      inst_m_d  = inst_x_q;
      inst_w_d  = inst_m_q;
    end
    stall_cnt_d = (inc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    flush_cnt_d = (inc_flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_d_q    <= NOP_INST;
      inst_x_q    <= NOP_INST;
      inst_m_q    <= NOP_INST;
      inst_w_q    <= NOP_INST;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      inst_d_q    <= inst_d_d;
      inst_x_q    <= inst_x_d;
      inst_m_q    <= inst_m_d;
      inst_w_q    <= inst_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign instD_com_o = inst_d_q;
  assign instX_com_o = inst_x_q;
  assign instM_com_o = inst_m_q;
  assign instW_com_o = inst_w_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_inst_tracker.sv
// Directed and randomized checks of pipe_inst_tracker against a stage-array reference model.
module tb_pipe_inst_tracker;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] RTYPE = 7'b0110011, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111, OPIMM = 7'b0010011;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] inst_f_i = '0;
  logic        fetch_valid_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic        dmem_wait_i = 1'b0;
  logic [31:0] inst_d, inst_x, inst_m, inst_w;
  logic        stall_f, flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] inst_d_s, inst_x_s, inst_m_s, inst_w_s;
  logic        stall_f_s, flush_s;
  logic [2:0]  stall_cnt_s, flush_cnt_s;

  int total = 0;
  int bad = 0;

  // Reference model: stage contents as an array (0=D 1=X 2=M 3=W) plus unbounded event counts.
  logic [31:0] stg [4];
  int unsigned n_stall, n_flush;

  always #5 clk_i = ~clk_i;

  pipe_inst_tracker #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_f_i(inst_f_i), .fetch_valid_i(fetch_valid_i),
    .br_taken_i(br_taken_i), .dmem_wait_i(dmem_wait_i),
    .instD_com_o(inst_d), .instX_com_o(inst_x), .instM_com_o(inst_m), .instW_com_o(inst_w),
    .stall_f_o(stall_f), .flush_o(flush), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_inst_tracker #(.CNT_W(3)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .inst_f_i(inst_f_i), .fetch_valid_i(fetch_valid_i),
    .br_taken_i(br_taken_i), .dmem_wait_i(dmem_wait_i),
    .instD_com_o(inst_d_s), .instX_com_o(inst_x_s), .instM_com_o(inst_m_s), .instW_com_o(inst_w_s),
    .stall_f_o(stall_f_s), .flush_o(flush_s), .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  // Which registers does this D instruction genuinely read?
  function automatic logic reads_reg(input logic [31:0] d, input logic [4:0] r);
    logic [6:0] op;
    logic       uses1, uses2;
    op    = d[6:0];
    uses1 = !(op == LUI || op == AUIPC || op == JAL);
    uses2 = (op == RTYPE || op == BRANCH);
    if (r == 5'd0) return 1'b0;
    return (uses1 && d[19:15] == r) || (uses2 && d[24:20] == r);
  endfunction

  function automatic logic model_hazard();
    logic h;
    h = 1'b0;
    for (int s = 1; s <= 2; s++)
      if (stg[s][6:0] == LOAD && reads_reg(stg[0], stg[s][11:7])) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] sat7(input int unsigned n);
    return (n > 7) ? 32'd7 : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, advance model, check state.
  task automatic cyc(input logic [31:0] f, input logic fv, input logic br,
                     input logic dw, input logic rs);
    logic hz;
    inst_f_i = f; fetch_valid_i = fv; br_taken_i = br; dmem_wait_i = dw; rst_i = rs;
    #1;
    hz = model_hazard();
    if (!rs) begin
      chk("stall_f", {31'b0, stall_f}, {31'b0, dw | (!br & hz)});
      chk("flush", {31'b0, flush}, {31'b0, !dw & br});
    end
    @(posedge clk_i);
    #1;
    if (rs) begin
      for (int s = 0; s < 4; s++) stg[s] = '0;
      n_stall = 0; n_flush = 0;
    end else if (dw) begin
      // frozen
    end else if (br) begin
      stg[3] = stg[2]; stg[2] = stg[1]; stg[1] = '0; stg[0] = '0;
      n_flush++;
    end else if (hz) begin
      stg[3] = stg[2]; stg[2] = stg[1]; stg[1] = '0;
      n_stall++;
    end else begin
      stg[3] = stg[2]; stg[2] = stg[1]; stg[1] = stg[0]; stg[0] = fv ? f : '0;
    end
    chk("instD", inst_d, stg[0]);
    chk("instX", inst_x, stg[1]);
    chk("instM", inst_m, stg[2]);
    chk("instW", inst_w, stg[3]);
    chk("stall_cnt", stall_cnt, n_stall);
    chk("flush_cnt", flush_cnt, n_flush);
    chk("stall_cnt_sat", {29'b0, stall_cnt_s}, sat7(n_stall));
    chk("flush_cnt_sat", {29'b0, flush_cnt_s}, sat7(n_flush));
  endtask

  logic [31:0] lw5, add6, sub7, sw5, lw0, add0, lui5, beq;
  logic [6:0]  ops [8];

  initial begin
    lw5  = mk(LOAD, 5, 1, 0);
    add6 = mk(RTYPE, 6, 5, 2);
    sub7 = mk(RTYPE, 7, 3, 4);
    sw5  = mk(STORE, 4, 2, 5);
    lw0  = mk(LOAD, 0, 1, 0);
    add0 = mk(RTYPE, 6, 0, 0);
    lui5 = mk(LUI, 5, 5, 5);
    beq  = mk(BRANCH, 0, 1, 2);
    ops  = '{LOAD, STORE, BRANCH, RTYPE, LUI, AUIPC, JAL, OPIMM};
    for (int s = 0; s < 4; s++) stg[s] = '0;
    n_stall = 0; n_flush = 0;
    @(posedge clk_i); #1;

    // Reset with fetch active
    cyc(add6, 1, 0, 0, 1);
    cyc(add6, 1, 0, 0, 1);
    chk("rst_instD", inst_d, 32'h0);
    chk("rst_stall_f", {31'b0, stall_f}, 32'h0);

    // Load-use: two bubbles, add held in D until lw reaches W
    cyc(lw5, 1, 0, 0, 0);
    cyc(add6, 1, 0, 0, 0);
    cyc(sub7, 1, 0, 0, 0);
    chk("lu_x_bubble1", inst_x, 32'h0);
    cyc(sub7, 1, 0, 0, 0);
    chk("lu_d_held", inst_d, add6);
    chk("lu_w_lw", inst_w, lw5);
    chk("lu_cnt2", stall_cnt, 32'd2);
    cyc(sub7, 1, 0, 0, 0);
    chk("lu_add_in_x", inst_x, add6);

    // No false stalls
    cyc(lw5, 1, 0, 0, 0); cyc(sw5, 1, 0, 0, 0); cyc('0, 0, 0, 0, 0);
    cyc(lw0, 1, 0, 0, 0); cyc(add0, 1, 0, 0, 0); cyc('0, 0, 0, 0, 0);
    cyc(lw5, 1, 0, 0, 0); cyc(lui5, 1, 0, 0, 0); cyc('0, 0, 0, 0, 0);
    chk("nofalse_cnt", stall_cnt, 32'd2);

    // Branch flush
    cyc(beq, 1, 0, 0, 0);
    cyc(add6, 1, 0, 0, 0);
    cyc(sub7, 1, 1, 0, 0);
    chk("br_d", inst_d, 32'h0);
    chk("br_m", inst_m, beq);
    chk("br_cnt", flush_cnt, 32'd1);

    // Freeze during load-use stall
    cyc('0, 0, 0, 0, 1);
    cyc(lw5, 1, 0, 0, 0);
    cyc(add6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(sub7, 1, 0, 1, 0);
      chk("frz_d", inst_d, add6);
      chk("frz_x", inst_x, lw5);
      chk("frz_cnt", stall_cnt, 32'd0);
    end
    cyc(sub7, 1, 0, 0, 0);
    cyc(sub7, 1, 0, 0, 0);
    chk("frz_cnt_end", stall_cnt, 32'd2);

    // Taken branch beats load-use
    cyc(sub7, 1, 0, 0, 0);
    cyc(lw5, 1, 0, 0, 0);
    cyc(add6, 1, 0, 0, 0);
    cyc(sub7, 1, 1, 0, 0);
    chk("prio_stall_cnt", stall_cnt, 32'd2);
    chk("prio_d", inst_d, 32'h0);
    chk("prio_flush_cnt", flush_cnt, 32'd1);

    // Saturation on the narrow instance
    cyc('0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(sub7, 1, 1, 0, 0);
    chk("sat_flush_s", {29'b0, flush_cnt_s}, 32'd7);
    chk("sat_flush_wide", flush_cnt, 32'd9);

    // Randomized traffic with small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      logic [31:0] f;
      logic        fv, br, dw, rs;
      f  = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      fv = ($urandom_range(0, 9) < 8);
      br = ($urandom_range(0, 9) < 1);
      dw = ($urandom_range(0, 9) < 2);
      rs = ($urandom_range(0, 99) < 2);
      cyc(f, fv, br, dw, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
